// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
// Divisors are tabulated for a 50 MHz reference clock and rescaled for other clock rates.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD24  = 2'd0,
    BAUD48  = 2'd1,
    BAUD96  = 2'd2,
    BAUD192 = 2'd3
  } baud_e;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;
`endif

  localparam int unsigned REF_CLK_HZ = 32'd50_000_000;
  localparam int unsigned OVERSAMPLE = 32'd16;
  localparam int unsigned RX_DIV [4] = '{32'd1302, 32'd651, 32'd326, 32'd163};

  // Rescale a reference divisor to clk_hz, rounding to nearest; never below 2.
  function automatic int unsigned scaled_div(input int unsigned clk_hz, input int unsigned sel);
    longint unsigned num;
    longint unsigned quo;
    num = 64'(RX_DIV[sel]) * 64'(clk_hz) + 64'(REF_CLK_HZ / 32'd2);
    quo = num / 64'(REF_CLK_HZ);
    if (quo < 64'd2) begin
      return 32'd2;
    end else begin
      return 32'(quo);
    end
  endfunction

  function automatic logic parity_of(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: latches the baud select while the receiver is idle and
// emits one registered tick per divisor period.
module uart_rx_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = REF_CLK_HZ
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_rate,
  input  logic       idle,
  output logic       tick
);

  localparam int unsigned DIV_B24  = scaled_div(CLK_HZ, 32'd0);
  localparam int unsigned DIV_B48  = scaled_div(CLK_HZ, 32'd1);
  localparam int unsigned DIV_B96  = scaled_div(CLK_HZ, 32'd2);
  localparam int unsigned DIV_B192 = scaled_div(CLK_HZ, 32'd3);
  localparam int unsigned CW       = (DIV_B24 > 32'd2) ? $clog2(DIV_B24) : 32'd1;

  localparam logic [CW-1:0] DIV_M1 [4] = '{
    CW'(DIV_B24 - 32'd1), CW'(DIV_B48 - 32'd1), CW'(DIV_B96 - 32'd1), CW'(DIV_B192 - 32'd1)
  };

  baud_e         baud_q, baud_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    baud_d = baud_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (idle && (baud_e'(baud_rate) != baud_q)) begin
      // A new rate restarts the divider so the first tick gets a full period.
      baud_d = baud_e'(baud_rate);
      cnt_d  = '0;
    end else if (cnt_q == DIV_M1[baud_q]) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      baud_q <= BAUD24;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 16x oversampled start/data/stop framing with a valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd selects odd) and parity_err.
module uart_rx_oversampler #(
  parameter int unsigned CLK_HZ     = uart_pkg::REF_CLK_HZ,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 32'd8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           baud_rate,
  input  logic                 rx,
  input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err
);
  import uart_pkg::*;

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = (DATA_BITS > 32'd1) ? $clog2(DATA_BITS) : 32'd1;
  localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 32'd2 - 32'd1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 32'd1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 32'd1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 armed_q, armed_d;
  logic                 tick_s;
  logic                 accept_s;
  logic                 parity_bad_s;
`ifdef UART_RX_PARITY_EN
  logic                 pbit_q, pbit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_rx_baud_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_baud_tick (
    .clock    (clock),
    .reset_n  (reset_n),
    .baud_rate(baud_rate),
    .idle     (state_q == ST_IDLE),
    .tick     (tick_s)
  );

  assign accept_s = rx_valid_q && rx_ready;

`ifdef UART_RX_PARITY_EN
  assign parity_bad_s = parity_of(32'(shift_q)) ^ pbit_q ^ parity_odd;
`else
  assign parity_bad_s = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    armed_d       = armed_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d        = pbit_q;
    parity_err_d  = 1'b0;
`endif
    if (accept_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        // After a break the line must be seen high before another start can begin.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
        if (tick_s && !rx_s_q && armed_q) begin
          state_d = ST_START;
          scnt_d  = '0;
          armed_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (scnt_q == SCNT_MID)) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            scnt_d  = '0;
            idx_d   = '0;
          end
        end else if (tick_s) begin
          scnt_d = scnt_q + SW'(1);
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_DATA: begin
        if (tick_s && (scnt_q == SCNT_LAST)) begin
          shift_d[idx_q] = rx_s_q;
          scnt_d         = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (tick_s) begin
          scnt_d = scnt_q + SW'(1);
        end else begin
          scnt_d = scnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s && (scnt_q == SCNT_LAST)) begin
          pbit_d  = rx_s_q;
          scnt_d  = '0;
          state_d = ST_STOP;
        end else if (tick_s) begin
          scnt_d = scnt_q + SW'(1);
        end else begin
          scnt_d = scnt_q;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s && (scnt_q == SCNT_LAST)) begin
          state_d = ST_IDLE;
          scnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_s;
`endif
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
          end else if (parity_bad_s) begin
            rx_data_d = rx_data_q;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_err_d = 1'b1;
          end else begin
            // Slot is free, or is being emptied this very cycle.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end else if (tick_s) begin
          scnt_d = scnt_q + SW'(1);
        end else begin
          scnt_d = scnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        scnt_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= ST_IDLE;
      scnt_q        <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      armed_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q        <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      armed_q       <= armed_d;
`ifdef UART_RX_PARITY_EN
      pbit_q        <= pbit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler, run at a 5 MHz clock so frames stay short:
// divisors become 130 (baud 00) and 16 (baud 11) clocks per tick.
module tb_uart_rx_oversampler;

  localparam int unsigned CLK_HZ = 5_000_000;
  localparam int BIT11 = 16 * 16;    // clocks per bit, baud 11
  localparam int BIT00 = 16 * 130;   // clocks per bit, baud 00
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Stop sample lands 8 + 16*(FRAME_BITS-1) ticks after start detect; detect adds 3..3+tick.
  localparam int STOP_TICKS = 8 + 16 * (FRAME_BITS - 1);
  localparam int LAT11_MIN  = STOP_TICKS * 16;
  localparam int LAT11_MAX  = STOP_TICKS * 16 + 20;
  localparam int LAT00_MIN  = STOP_TICKS * 130;
  localparam int LAT00_MAX  = STOP_TICKS * 130 + 135;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] baud_rate;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       parity_err;
  logic       par_flip;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int v_rise = 0, v_high = 0, v_rise_cyc = 0;
  int fe_rise = 0, fe_high = 0, ov_rise = 0, ov_high = 0, pe_rise = 0;
  logic v_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;
  int b_vr, b_vh, b_fr, b_fh, b_or, b_oh, b_pr;

  uart_rx_oversampler #(
    .CLK_HZ(CLK_HZ)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_rate  (baud_rate),
    .rx         (rx),
    .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
    .parity_err (parity_err),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  // Event monitor, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clock);
    #1;
    cyc++;
    if (rx_valid && !v_prev) begin
      v_rise++;
      v_rise_cyc = cyc;
    end
    if (rx_valid) v_high++;
    if (frame_err && !fe_prev) fe_rise++;
    if (frame_err) fe_high++;
    if (overrun_err && !ov_prev) ov_rise++;
    if (overrun_err) ov_high++;
`ifdef UART_RX_PARITY_EN
    if (parity_err && !pe_prev) pe_rise++;
    pe_prev = parity_err;
`endif
    v_prev  = rx_valid;
    fe_prev = frame_err;
    ov_prev = overrun_err;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_vr = v_rise; b_vh = v_high; b_fr = fe_rise; b_fh = fe_high;
    b_or = ov_rise; b_oh = ov_high; b_pr = pe_rise;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive the first nsend bits of a frame, LSB first; leaves rx at the last bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int bitclk,
                            input int nsend);
    logic [FRAME_BITS-1:0] bits;
    int nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^d) ^ parity_odd ^ par_flip;
`endif
    bits[FRAME_BITS-1] = stop_lvl;
    nb = (nsend < FRAME_BITS) ? nsend : FRAME_BITS;
    start_cyc = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      wait_clk(bitclk);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    rx        = 1'b1;
    rx_ready  = 1'b0;
    baud_rate = 2'b11;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    par_flip   = 1'b0;
`endif
    wait_clk(4);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun_err), 0);
    reset_n = 1'b1;
    wait_clk(32);

    // 0xA5 at baud 11, consumer always ready
    rx_ready = 1'b1;
    mark();
    send_frame(8'hA5, 1'b1, BIT11, FRAME_BITS);
    rx = 1'b1;
    wait_clk(BIT11);
    check("a5_data", int'(rx_data), 'hA5);
    check("a5_valid_rises", v_rise - b_vr, 1);
    check("a5_valid_width", v_high - b_vh, 1);
    check("a5_no_frame_err", fe_rise - b_fr, 0);
    check("a5_latency", int'((v_rise_cyc - start_cyc >= LAT11_MIN) &&
                             (v_rise_cyc - start_cyc <= LAT11_MAX)), 1);
    check("a5_busy_idle", int'(busy), 0);

    // 0x3C at baud 00, held until accepted
    rx_ready  = 1'b0;
    baud_rate = 2'b00;
    wait_clk(32);
    mark();
    send_frame(8'h3C, 1'b1, BIT00, FRAME_BITS);
    rx = 1'b1;
    wait_clk(200);
    check("3c_valid_held", int'(rx_valid), 1);
    check("3c_data", int'(rx_data), 'h3C);
    check("3c_valid_rises", v_rise - b_vr, 1);
    check("3c_latency", int'((v_rise_cyc - start_cyc >= LAT00_MIN) &&
                             (v_rise_cyc - start_cyc <= LAT00_MAX)), 1);
    rx_ready = 1'b1;
    wait_clk(1);
    check("3c_valid_cleared", int'(rx_valid), 0);
    baud_rate = 2'b11;
    wait_clk(32);

    // Three-tick glitch: false start
    mark();
    rx = 1'b0;
    wait_clk(40);
    check("glitch_busy", int'(busy), 1);
    wait_clk(8);
    rx = 1'b1;
    wait_clk(2 * BIT11);
    check("glitch_busy_fell", int'(busy), 0);
    check("glitch_no_valid", v_rise - b_vr, 0);
    check("glitch_no_frame_err", fe_rise - b_fr, 0);

    // 0x55 with stop bit 0, line then held low (break)
    mark();
    send_frame(8'h55, 1'b0, BIT11, FRAME_BITS);
    wait_clk(2 * BIT11);
    check("break_no_retrigger", int'(busy), 0);
    rx = 1'b1;
    wait_clk(BIT11);
    check("ferr_pulses", fe_rise - b_fr, 1);
    check("ferr_width", fe_high - b_fh, 1);
    check("ferr_no_valid", v_rise - b_vr, 0);
    check("ferr_valid_low", int'(rx_valid), 0);
    check("ferr_data_kept", int'(rx_data), 'h3C);

    // 0x11 then 0x22 back to back, nobody accepting
    rx_ready = 1'b0;
    mark();
    send_frame(8'h11, 1'b1, BIT11, FRAME_BITS);
    send_frame(8'h22, 1'b1, BIT11, FRAME_BITS);
    rx = 1'b1;
    wait_clk(BIT11);
    check("ovr_data_kept", int'(rx_data), 'h11);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_valid_rises", v_rise - b_vr, 1);
    check("ovr_pulses", ov_rise - b_or, 1);
    check("ovr_width", ov_high - b_oh, 1);
    rx_ready = 1'b1;
    wait_clk(2);

    // Reset during data bit 4, then a clean 0x7E
    send_frame(8'h7E, 1'b1, BIT11, 5);
    rx = 1'b1;
    wait_clk(BIT11 / 2);
    check("midframe_busy", int'(busy), 1);
    reset_n = 1'b0;
    wait_clk(3);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun_err), 0);
    reset_n = 1'b1;
    wait_clk(32);
    mark();
    send_frame(8'h7E, 1'b1, BIT11, FRAME_BITS);
    rx = 1'b1;
    wait_clk(BIT11);
    check("7e_data", int'(rx_data), 'h7E);
    check("7e_valid_rises", v_rise - b_vr, 1);
    check("7e_no_frame_err", fe_rise - b_fr, 0);
    check("7e_no_overrun", ov_rise - b_or, 0);

`ifdef UART_RX_PARITY_EN
    // 0x7E with the wrong even-parity bit
    par_flip = 1'b1;
    mark();
    send_frame(8'h7E, 1'b1, BIT11, FRAME_BITS);
    rx = 1'b1;
    wait_clk(BIT11);
    par_flip = 1'b0;
    check("par_err_pulse", pe_rise - b_pr, 1);
    check("par_no_valid", v_rise - b_vr, 0);
    check("par_no_frame_err", fe_rise - b_fr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
